// File: rtl/cdf_data_path_pkg.sv
// Shared constants, FSM encoding and the equalization scaling helper for the
// histogram-equalization CDF pass.
package hist_eq_pkg;

  localparam int LANE_WIDTH    = 32;
  localparam int LANES         = 4;
  localparam int BINS          = 256;
  localparam int PIXELS        = 65536;
  localparam int DEF_HIST_BASE = 0;
  localparam int DEF_CDF_BASE  = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_ACC  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Maps a raw CDF value to an 8-bit LUT entry for a PIXELS-pixel image.
  function automatic logic [31:0] scale_lane(input logic [31:0] cdf);
    logic [39:0] prod;
    logic [39:0] shifted;
    prod    = {8'd0, cdf} * 40'(BINS - 1);
    shifted = prod >> $clog2(PIXELS);
    if (shifted > 40'(BINS - 1)) return 32'(BINS - 1);
    return {24'd0, shifted[7:0]};
  endfunction

endpackage

// File: rtl/cdf_data_path_if.sv
// Scratch-memory port of the CDF pass: one read channel and one write channel.
interface cdf_data_path_if;
  // Strobe semantics: read_enable/write_enable are single-cycle strobes with no
  // back-pressure; rdata is valid exactly one cycle after read_enable, and
  // addresses/wdata are held at 0 whenever their strobe is low.
  logic         read_enable;
  logic [15:0]  read_address;
  logic [127:0] rdata;
  logic         write_enable;
  logic [15:0]  write_address;
  logic [127:0] wdata;

  modport master (
    output read_enable, read_address, write_enable, write_address, wdata,
    input  rdata
  );

  modport slave (
    input  read_enable, read_address, write_enable, write_address, wdata,
    output rdata
  );
endinterface

// File: rtl/cdf_data_path_prefix_adder.sv
// Combinational 4-lane prefix adder: lane j = total + sum of input lanes 0..j,
// all modulo 2^LANE_W.
module cdf_prefix_adder
  import hist_eq_pkg::*;
#(
  parameter int LANE_W = LANE_WIDTH
) (
  input  logic [LANE_W-1:0]       total,
  input  logic [LANES*LANE_W-1:0] word,
  output logic [LANES*LANE_W-1:0] cdf
);

  logic [LANE_W-1:0] acc;

  always_comb begin
    acc = total;
    cdf = '0;
    for (int j = 0; j < LANES; j++) begin
      acc = acc + word[j*LANE_W +: LANE_W];
      cdf[j*LANE_W +: LANE_W] = acc;
    end
  end

endmodule

// File: rtl/cdf_data_path.sv
// Reads the histogram word by word, writes the running CDF back to scratch.
// Build option: define CDF_SCALE_EN to write 8-bit equalization LUT entries.
module cdf_data_path
  import hist_eq_pkg::*;
#(
  parameter int HIST_BASE  = DEF_HIST_BASE,
  parameter int CDF_BASE   = DEF_CDF_BASE,
  parameter int HIST_WORDS = 64,
  parameter int LANE_W     = LANE_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  cdf_data_path_if.master   scratch,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg
);

  localparam logic [15:0] LAST_K = 16'(HIST_WORDS - 1);

  state_t                    state;
  logic [15:0]               k;
  logic [LANE_W-1:0]         total;
  logic [LANE_W-1:0]         cdf_last;
  logic [LANES*LANE_W-1:0]   cdf_word;
  logic [LANES*LANE_W-1:0]   out_word;

  assign state_dbg = state;

  cdf_prefix_adder #(.LANE_W(LANE_W)) u_prefix (
    .total (total),
    .word  (scratch.rdata),
    .cdf   (cdf_word)
  );

`ifdef CDF_SCALE_EN
  for (genvar j = 0; j < LANES; j++) begin : g_scale
    assign out_word[j*LANE_W +: LANE_W] = scale_lane(cdf_word[j*LANE_W +: LANE_W]);
  end
`else
  assign out_word = cdf_word;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= S_IDLE;
      k                     <= '0;
      total                 <= '0;
      cdf_last              <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      scratch.read_enable   <= 1'b0;
      scratch.read_address  <= '0;
      scratch.write_enable  <= 1'b0;
      scratch.write_address <= '0;
      scratch.wdata         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state                <= S_RD;
            busy                 <= 1'b1;
            scratch.read_enable  <= 1'b1;
            scratch.read_address <= 16'(HIST_BASE) + k;
          end
        end
        S_RD: begin
          state                <= S_ACC;
          scratch.read_enable  <= 1'b0;
          scratch.read_address <= '0;
        end
        S_ACC: begin
          // rdata is valid now; the running total stays raw even when scaled.
          state                 <= S_WR;
          cdf_last              <= cdf_word[(LANES-1)*LANE_W +: LANE_W];
          scratch.write_enable  <= 1'b1;
          scratch.write_address <= 16'(CDF_BASE) + k;
          scratch.wdata         <= out_word;
        end
        S_WR: begin
          scratch.write_enable  <= 1'b0;
          scratch.write_address <= '0;
          scratch.wdata         <= '0;
          total                 <= cdf_last;
          k                     <= k + 16'd1;
          if (k < LAST_K) begin
            state                <= S_RD;
            scratch.read_enable  <= 1'b1;
            scratch.read_address <= 16'(HIST_BASE) + k + 16'd1;
          end else begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          k     <= '0;
          total <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_data_path.sv
// Directed bench for cdf_data_path: cycle-exact strobe checks against a CDF
// model queue plus hand-computed spot values per histogram pattern.
module tb_cdf_data_path;
  import hist_eq_pkg::*;

  logic   clock;
  logic   reset;
  logic   start;
  logic   busy;
  logic   done;
  state_t state_dbg;

  cdf_data_path_if scr();

  cdf_data_path dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .scratch   (scr),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scratch memory model and write monitor
  logic [127:0] mem [0:255];
  logic [127:0] cap [0:255];
  int           wr_count;
  logic [127:0] exp_q [$];
  int           checks;
  int           errors;

  always @(posedge clock) begin
    scr.rdata <= scr.read_enable ? mem[scr.read_address[7:0]] : '0;
    if (scr.write_enable) begin
      cap[scr.write_address[7:0]] = scr.wdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at time %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_lane(input logic [31:0] c);
`ifdef CDF_SCALE_EN
    logic [39:0] p;
    p = (40'(c) * 40'd255) >> 16;
    return (p > 40'd255) ? 32'd255 : p[31:0];
`else
    return c;
`endif
  endfunction

  task automatic build_expected();
    logic [31:0]  tot;
    logic [127:0] w;
    exp_q.delete();
    tot = '0;
    for (int kk = 0; kk < 64; kk++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        tot = tot + mem[kk][32*j +: 32];
        w[32*j +: 32] = exp_lane(tot);
      end
      exp_q.push_back(w);
    end
  endtask

  // driver tasks
  task automatic set_hist(input int mode);
    for (int kk = 0; kk < 256; kk++) begin
      mem[kk] = '0;
      cap[kk] = '1;
    end
    for (int kk = 0; kk < 64; kk++)
      for (int j = 0; j < 4; j++)
        case (mode)
          1: mem[kk][32*j +: 32] = 32'd256;
          2: mem[kk][32*j +: 32] = (4*kk + j == 200) ? 32'd65536 : 32'd0;
          3: mem[kk][32*j +: 32] = 32'(4*kk + j);
          default: mem[kk][32*j +: 32] = 32'd0;
        endcase
    if (mode == 4) mem[0] = {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF};
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_re"}, 128'(scr.read_enable), 128'(0));
    check({tag, "_ra"}, 128'(scr.read_address), 128'(0));
    check({tag, "_we"}, 128'(scr.write_enable), 128'(0));
    check({tag, "_wa"}, 128'(scr.write_address), 128'(0));
    check({tag, "_wd"}, scr.wdata, 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
  endtask

  task automatic run_pass(input int extra_start, input int reset_at);
    logic         exp_re, exp_we;
    logic [127:0] exp_w;
    build_expected();
    wr_count = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 1; c <= 194; c++) begin
      exp_re = (c % 3 == 1) && (c <= 190);
      exp_we = (c % 3 == 0) && (c >= 3) && (c <= 192);
      exp_w  = '0;
      if (exp_we) exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("rd_en", 128'(scr.read_enable), 128'(exp_re));
      check("rd_addr", 128'(scr.read_address), exp_re ? 128'((c - 1) / 3) : 128'(0));
      check("wr_en", 128'(scr.write_enable), 128'(exp_we));
      check("wr_addr", 128'(scr.write_address), exp_we ? 128'(64 + (c - 3) / 3) : 128'(0));
      check("wdata", scr.wdata, exp_w);
      check("busy", 128'(busy), 128'(c <= 193));
      check("done", 128'(done), 128'(c == 193));
      start = (c == extra_start);
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        check("rst_state", 128'(state_dbg), 128'(S_IDLE));
        check_quiet("abort");
        repeat (20) @(negedge clock);
        check_quiet("abort_idle");
        check("abort_writes", 128'(wr_count), 128'(16));
        return;
      end
      @(negedge clock);
    end
    check("write_count", 128'(wr_count), 128'(64));
  endtask

  // directed sequence
  initial begin
    checks = 0;
    errors = 0;
    wr_count = 0;
    start = 1'b0;
    reset = 1'b1;
    set_hist(0);
    repeat (3) @(negedge clock);
    check("reset_state", 128'(state_dbg), 128'(S_IDLE));
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);

    // all-zero histogram
    run_pass(0, 0);
    check("zero_w0", cap[64], 128'(0));
    check("zero_w63", cap[127], 128'(0));

    // 256 counts per bin
    set_hist(1);
    run_pass(0, 0);
`ifdef CDF_SCALE_EN
    check("flat_w0", cap[64], {32'd3, 32'd2, 32'd1, 32'd0});
    check("flat_last", 128'(cap[127][127:96]), 128'(255));
`else
    check("flat_w0", cap[64], {32'd1024, 32'd768, 32'd512, 32'd256});
    check("flat_last", 128'(cap[127][127:96]), 128'(65536));
`endif

    // every pixel in bin 200
    set_hist(2);
    run_pass(0, 0);
    check("spike_w49", cap[113], 128'(0));
`ifdef CDF_SCALE_EN
    check("spike_w50", cap[114], {4{32'd255}});
    check("spike_w63", cap[127], {4{32'd255}});
`else
    check("spike_w50", cap[114], {4{32'd65536}});
    check("spike_w63", cap[127], {4{32'd65536}});
`endif

    // ramp histogram, second start at cycle 40 ignored
    set_hist(3);
    run_pass(40, 0);
`ifdef CDF_SCALE_EN
    check("ramp_w0", cap[64], 128'(0));
    check("ramp_last", 128'(cap[127][127:96]), 128'(127));
`else
    check("ramp_w0", cap[64], {32'd6, 32'd3, 32'd1, 32'd0});
    check("ramp_last", 128'(cap[127][127:96]), 128'(32640));
`endif

    // reset at cycle 50 aborts, then a clean full pass
    run_pass(0, 50);
    run_pass(0, 0);
`ifdef CDF_SCALE_EN
    check("rerun_last", 128'(cap[127][127:96]), 128'(127));
`else
    check("rerun_last", 128'(cap[127][127:96]), 128'(32640));
`endif

    // modulo-2^32 wrap
    set_hist(4);
    run_pass(0, 0);
`ifdef CDF_SCALE_EN
    check("wrap_w0", cap[64], {32'd0, 32'd0, 32'd0, 32'd255});
    check("wrap_w63", cap[127], 128'(0));
`else
    check("wrap_w0", cap[64], {32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF});
    check("wrap_w63", cap[127], {4{32'd1}});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdf_data_path.md
CDF_DATA_PATH -- requirements
Module: cdf_data_path

Interface
REQ-001 Parameters SHALL be:
- HIST_BASE, default 0: scratch address of histogram word 0.
- CDF_BASE, default 64: scratch address of CDF word 0.
- HIST_WORDS, default 64: 128-bit words per histogram (256 bins, 4 lanes each).
- LANE_W, default 32: bits per bin lane.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse from top_level_control after the histogram pass completes.
- read_enable  out  1  scratch read strobe.
- read_address  out  16  scratch read address.
- rdata  in  128  scratch read data, valid exactly 1 cycle after read_enable.
- write_enable  out  1  scratch write strobe.
- write_address  out  16  scratch write address.
- wdata  out  128  scratch write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
REQ-003 Lane j of any 128-bit word SHALL occupy bits [32j+31:32j], lane 0 = lowest bin; bin index = 4*word + j.

Function
REQ-004 FSM states SHALL be IDLE, RD, ACC, WR, FIN.
REQ-005 IDLE->RD on start; RD->ACC always; ACC->WR always; WR->RD if word index k < HIST_WORDS-1, else WR->FIN; FIN->IDLE always.
REQ-006 In RD: read_enable=1, read_address=HIST_BASE+k.
REQ-007 In ACC: capture rdata; compute cdf_j = total + sum(lanes 0..j) for j=0..3; register the results as the write word.
REQ-008 In WR: write_enable=1, write_address=CDF_BASE+k, wdata=registered CDF word; total <= cdf_3; k <= k+1.
REQ-009 In FIN: done=1 for exactly one cycle; k and total cleared.
REQ-010 Timing: first read_enable SHALL occur the cycle after start is sampled; word k SHALL be read at cycle 1+3k and written at cycle 3+3k; done SHALL occur at cycle 193 after start.
REQ-011 start while busy SHALL be ignored with no effect on k, total or outputs.
REQ-012 Arithmetic SHALL be LANE_W-bit unsigned with wrap modulo 2^32; no overflow flag.
REQ-013 read_enable and write_enable SHALL never be high in the same cycle.
REQ-014 write_address, read_address and wdata SHALL be 0 whenever their strobe is low.

Reset
REQ-015 While reset is high at a clock edge: state=IDLE, k=0, total=0, and all outputs 0 (read_enable, read_address, write_enable, write_address, wdata, busy, done).
REQ-016 Reset asserted mid-operation SHALL abort the pass with no further writes; the next start SHALL restart from word 0 with total=0.

Configuration
REQ-017 With macro CDF_SCALE_EN defined, each written lane SHALL be min(255, (cdf_j*255)>>16) in bits [7:0], with upper bits 0; this is the equalization LUT for a 65536-pixel image.
REQ-018 Without CDF_SCALE_EN, each written lane SHALL hold raw cdf_j.
REQ-019 The running total SHALL be raw cdf in both builds; timing SHALL be identical in both builds.

Structure
REQ-020 Package hist_eq_pkg SHALL hold the lane width, lane count (4), bin count (256), pixel count (65536), the state encoding constants, and the default HIST_BASE/CDF_BASE.
REQ-021 A combinational 4-lane prefix adder sub-module, cdf_prefix_adder (inputs: total and 128-bit word; output: 128-bit CDF word), SHALL be instantiated once.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- All-zero histogram, start -> 64 writes of 0 to addresses 64..127; done at cycle 193; busy low at cycle 194.
- 256 counts per bin -> lane j of word k = 256*(4k+j+1); word 63 lane 3 = 65536; with CDF_SCALE_EN that lane = 255 and bin 0 = 0.
- All 65536 counts in bin 200 -> bins 0..199 = 0, bins 200..255 = 65536 (scaled: 255).
- Second start pulse at cycle 40 of a pass -> ignored; done still at cycle 193; exactly 64 writes.
- Reset asserted at cycle 50 for one cycle -> no writes after reset; a new start produces a full correct 64-word pass.
- Each write checked against the C-model CDF file (address, then all 4 lanes); any mismatch reported with simulation time.
